b2r_stream_converter: RTL and testbench

//  Streaming block-to-row converter. It sits between the multi-core MAC array output and row-ordered consumers
//  (softmax, layernorm, writeback). It takes one core-mode tile per beat and emits one full matrix row per beat.
//  Two ping-pong tile-row banks let input for tile-row k+1 be accepted while rows of tile-row k drain.

---
 rtl/b2r_stream_if.sv | 27 ++
 rtl/b2r_stream_converter.sv | 176 +++++++++++++++++
 tb/tb_b2r_stream_converter.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/b2r_stream_if.sv
// Streaming bundle for the block-to-row converter: a tile-in channel and a row-out channel,
// each with its own valid/ready handshake.
interface b2r_stream_if #(
    parameter int IN_W  = 256,
    parameter int OUT_W = 1024,
    parameter int IDX_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic [IDX_W-1:0] out_row_idx;
    logic             out_last;

    // master: the environment around the converter (tile producer + row consumer)
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_row_idx, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_row_idx, out_last
    );
endinterface

// File: rtl/b2r_stream_converter.sv
// Block-to-row converter: accepts one core-packed tile per beat into ping-pong tile-row banks
// and emits full matrix rows, one per beat, with backpressure on both sides.
module b2r_stream_converter #(
    parameter int WIDTH       = 16,
    parameter int ROW         = 256,
    parameter int COL         = 64,
    parameter int BLOCK_SIZE  = 2,
    parameter int NUM_CORES_H = 2,
    parameter int NUM_CORES_V = 2,
    parameter bit MSB_FIRST   = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic        done,
    b2r_stream_if.slave bus
);
    localparam int B        = BLOCK_SIZE;
    localparam int CHUNK    = B * B;
    localparam int TILE_R   = B * NUM_CORES_V;
    localparam int TILE_C   = B * NUM_CORES_H;
    localparam int NTC      = COL / TILE_C;
    localparam int NTR      = ROW / TILE_R;
    localparam int N_IN     = CHUNK * NUM_CORES_H * NUM_CORES_V;
    localparam int IDX_W    = (ROW > 1) ? $clog2(ROW) : 1;
    localparam int TC_W     = (NTC > 1) ? $clog2(NTC) : 1;
    localparam int TR_W     = (NTR > 1) ? $clog2(NTR) : 1;
    localparam int WTR_W    = $clog2(NTR + 1);
    localparam int ROWSEL_W = (TILE_R > 1) ? $clog2(TILE_R) : 1;

    if (((ROW % TILE_R) != 0) || ((COL % TILE_C) != 0)) begin : g_bad_geometry
        $error("b2r_stream_converter: ROW/COL must be multiples of the tile size");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Each bank holds one tile-row, split by tile column so the write column is selected by wr_tc alone
    logic [WIDTH-1:0] bank [2][TILE_R][NTC][TILE_C];

    logic [1:0]          full;
    logic [1:0]          full_set;
    logic [1:0]          full_clr;
    logic                wr_bank;
    logic                rd_bank;
    logic [TC_W-1:0]     wr_tc;
    logic [WTR_W-1:0]    wr_tr;
    logic [ROWSEL_W-1:0] rd_row;
    logic [TR_W-1:0]     rd_tr;

    logic in_ready_c;
    logic out_valid_c;
    logic out_last_c;
    logic in_fire;
    logic out_fire;
    logic fill_done;
    logic drain_done;

    function automatic int slot_pos(input int n, input int total);
        return MSB_FIRST ? (total - 1 - n) : n;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (en) state_nxt = S_RUN;
            S_RUN:   if (out_fire && out_last_c) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        out_last_c  = 1'b0;
        done        = 1'b0;
        case (state)
            S_RUN: begin
                in_ready_c  = !full[wr_bank] && (wr_tr < WTR_W'(NTR));
                out_valid_c = full[rd_bank];
                out_last_c  = full[rd_bank] && (rd_tr == TR_W'(NTR - 1))
                              && (rd_row == ROWSEL_W'(TILE_R - 1));
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    assign in_fire    = in_ready_c && bus.in_valid;
    assign out_fire   = out_valid_c && bus.out_ready;
    assign fill_done  = in_fire && (wr_tc == TC_W'(NTC - 1));
    assign drain_done = out_fire && (rd_row == ROWSEL_W'(TILE_R - 1));

    // Fill and drain always target different banks, so both updates may land in one cycle
    always_comb begin
        full_set = 2'b00;
        full_clr = 2'b00;
        if (fill_done)  full_set[wr_bank] = 1'b1;
        if (drain_done) full_clr[rd_bank] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || (state != S_RUN)) begin
            full    <= 2'b00;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            wr_tc   <= '0;
            wr_tr   <= '0;
            rd_row  <= '0;
            rd_tr   <= '0;
        end else begin
            full <= (full | full_set) & ~full_clr;
            if (in_fire) begin
                if (fill_done) begin
                    wr_tc   <= '0;
                    wr_tr   <= wr_tr + 1'b1;
                    wr_bank <= ~wr_bank;
                end else begin
                    wr_tc <= wr_tc + 1'b1;
                end
            end
            if (out_fire) begin
                if (drain_done) begin
                    rd_row  <= '0;
                    rd_bank <= ~rd_bank;
                    rd_tr   <= (rd_tr == TR_W'(NTR - 1)) ? '0 : rd_tr + 1'b1;
                end else begin
                    rd_row <= rd_row + 1'b1;
                end
            end
        end
    end

    // Core k = v*NUM_CORES_H + h owns a CHUNK of slots; element (i,j) lands at tile row v*B+i, col h*B+j
    always_ff @(posedge clk) begin
        if (in_fire) begin
            for (int v = 0; v < NUM_CORES_V; v++) begin
                for (int h = 0; h < NUM_CORES_H; h++) begin
                    for (int i = 0; i < B; i++) begin
                        for (int j = 0; j < B; j++) begin
                            bank[wr_bank][v*B+i][wr_tc][h*B+j] <=
                                bus.in_data[slot_pos((v*NUM_CORES_H + h)*CHUNK + i*B + j, N_IN)*WIDTH +: WIDTH];
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        bus.out_data = '0;
        for (int c = 0; c < COL; c++) begin
            bus.out_data[slot_pos(c, COL)*WIDTH +: WIDTH] = bank[rd_bank][rd_row][c / TILE_C][c % TILE_C];
        end
    end

    assign bus.in_ready    = in_ready_c;
    assign bus.out_valid   = out_valid_c;
    assign bus.out_last    = out_last_c;
    assign bus.out_row_idx = IDX_W'(int'(rd_tr) * TILE_R + int'(rd_row));

endmodule

// File: tb/tb_b2r_stream_converter.sv
// Scoreboard bench for b2r_stream_converter: two DUTs (LSB-first and MSB-first) share stimulus;
// expected rows come straight from a reference matrix and are checked by a decoupled monitor.
module tb_b2r_stream_converter;
    localparam int W      = 16;
    localparam int ROW    = 8;
    localparam int COL    = 8;
    localparam int B      = 2;
    localparam int NCH    = 2;
    localparam int NCV    = 2;
    localparam int CHUNK  = B * B;
    localparam int TILE_R = B * NCV;
    localparam int TILE_C = B * NCH;
    localparam int NTC    = COL / TILE_C;
    localparam int NTR    = ROW / TILE_R;
    localparam int N_IN   = CHUNK * NCH * NCV;
    localparam int IN_W   = W * N_IN;
    localparam int OUT_W  = W * COL;
    localparam int IDX_W  = $clog2(ROW);

    typedef struct {
        logic [OUT_W-1:0] data;
        logic [IDX_W-1:0] idx;
        logic             last;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    logic done_a;
    logic done_b;

    b2r_stream_if #(.IN_W(IN_W), .OUT_W(OUT_W), .IDX_W(IDX_W)) ifa ();
    b2r_stream_if #(.IN_W(IN_W), .OUT_W(OUT_W), .IDX_W(IDX_W)) ifb ();

    b2r_stream_converter #(
        .WIDTH(W), .ROW(ROW), .COL(COL), .BLOCK_SIZE(B),
        .NUM_CORES_H(NCH), .NUM_CORES_V(NCV), .MSB_FIRST(1'b0)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .done(done_a), .bus(ifa)
    );

    b2r_stream_converter #(
        .WIDTH(W), .ROW(ROW), .COL(COL), .BLOCK_SIZE(B),
        .NUM_CORES_H(NCH), .NUM_CORES_V(NCV), .MSB_FIRST(1'b1)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .done(done_b), .bus(ifb)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int out_ready_pct = 100;
    int frames_done = 0;
    int frames_target = 0;
    logic [W-1:0] mat [ROW][COL];
    exp_t q_a[$];
    exp_t q_b[$];

    task automatic check_output(input string name, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [OUT_W-1:0] pack_row(input int r, input bit msb);
        logic [OUT_W-1:0] v;
        v = '0;
        for (int c = 0; c < COL; c++) begin
            int p;
            p = msb ? (COL - 1 - c) : c;
            v[p*W +: W] = mat[r][c];
        end
        return v;
    endfunction

    // Tile (tr,tc) as the MAC array would emit it: core k = v*NCH+h, element (i,j) at slot k*CHUNK+i*B+j
    function automatic logic [IN_W-1:0] pack_tile(input int tr, input int tc, input bit msb);
        logic [IN_W-1:0] t;
        t = '0;
        for (int v = 0; v < NCV; v++)
            for (int h = 0; h < NCH; h++)
                for (int i = 0; i < B; i++)
                    for (int j = 0; j < B; j++) begin
                        int s;
                        int p;
                        s = (v*NCH + h)*CHUNK + i*B + j;
                        p = msb ? (N_IN - 1 - s) : s;
                        t[p*W +: W] = mat[tr*TILE_R + v*B + i][tc*TILE_C + h*B + j];
                    end
        return t;
    endfunction

    task automatic fill_matrix(input bit pattern);
        for (int r = 0; r < ROW; r++)
            for (int c = 0; c < COL; c++)
                mat[r][c] = pattern ? W'(r*COL + c) : W'($urandom_range(16'hFFFF));
    endtask

    task automatic start_frame();
        exp_t e;
        for (int r = 0; r < ROW; r++) begin
            e.idx  = IDX_W'(r);
            e.last = (r == ROW - 1);
            e.data = pack_row(r, 1'b0);
            q_a.push_back(e);
            e.data = pack_row(r, 1'b1);
            q_b.push_back(e);
        end
        en = 1'b1;
        @(posedge clk); #1;
        en = 1'b0;
    endtask

    task automatic send_beat(input logic [IN_W-1:0] da, input logic [IN_W-1:0] db, input int gap_pct);
        int waited;
        waited = 0;
        while ($urandom_range(99) < gap_pct) begin
            ifa.in_valid = 1'b0;
            ifb.in_valid = 1'b0;
            @(posedge clk); #1;
        end
        ifa.in_valid = 1'b1;
        ifb.in_valid = 1'b1;
        ifa.in_data  = da;
        ifb.in_data  = db;
        forever begin
            @(negedge clk);
            if (ifa.in_ready) break;
            waited++;
            if (waited > 500) begin
                checks++;
                errors++;
                $display("[TB] FAIL beat_accept: in_ready still %0b after %0d cycles, required 1", ifa.in_ready, waited);
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        ifa.in_valid = 1'b0;
        ifb.in_valid = 1'b0;
    endtask

    task automatic apply_stimulus(input int first, input int count, input int gap_pct);
        for (int n = first; n < first + count; n++)
            send_beat(pack_tile(n / NTC, n % NTC, 1'b0), pack_tile(n / NTC, n % NTC, 1'b1), gap_pct);
    endtask

    task automatic wait_frame(input string name);
        frames_target++;
        for (int k = 0; k < 3000; k++) begin
            if (frames_done >= frames_target && q_a.size() == 0 && q_b.size() == 0) break;
            @(posedge clk); #1;
        end
        checks++;
        if (frames_done < frames_target || q_a.size() != 0 || q_b.size() != 0) begin
            errors++;
            $display("[TB] FAIL %s: frame end not reached, done count %0d required %0d, rows left %0d/%0d",
                     name, frames_done, frames_target, q_a.size(), q_b.size());
            frames_done = frames_target;
            q_a.delete();
            q_b.delete();
        end
        @(negedge clk);
        check_output({name, "_idle_in_ready"}, OUT_W'(ifa.in_ready), '0);
        @(posedge clk); #1;
    endtask

    always @(posedge clk) begin
        #1;
        ifa.out_ready = ($urandom_range(99) < out_ready_pct);
        ifb.out_ready = ifa.out_ready;
    end

    // Monitor: pops one expected row per accepted output, checks done follows the final row and stalled data holds
    logic             exp_done [2];
    logic             hold_v   [2];
    logic [OUT_W-1:0] hold_d   [2];
    logic             m_valid, m_ready, m_last, m_done;
    logic [OUT_W-1:0] m_data;
    logic [IDX_W-1:0] m_idx;
    exp_t             m_exp;

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            m_valid = d ? ifb.out_valid   : ifa.out_valid;
            m_ready = d ? ifb.out_ready   : ifa.out_ready;
            m_last  = d ? ifb.out_last    : ifa.out_last;
            m_data  = d ? ifb.out_data    : ifa.out_data;
            m_idx   = d ? ifb.out_row_idx : ifa.out_row_idx;
            m_done  = d ? done_b          : done_a;
            if (!rst_n) begin
                exp_done[d] = 1'b0;
                hold_v[d]   = 1'b0;
            end else begin
                check_output(d ? "done_b" : "done_a", OUT_W'(m_done), OUT_W'(exp_done[d]));
                if (d == 0 && m_done) frames_done++;
                exp_done[d] = 1'b0;
                if (hold_v[d]) begin
                    check_output(d ? "hold_valid_b" : "hold_valid_a", OUT_W'(m_valid), OUT_W'(1));
                    check_output(d ? "hold_data_b" : "hold_data_a", m_data, hold_d[d]);
                end
                hold_v[d] = m_valid && !m_ready;
                hold_d[d] = m_data;
                if (m_valid && m_ready) begin
                    if ((d ? q_b.size() : q_a.size()) == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_row_%0d: got row idx %0d, required no output", d, m_idx);
                    end else begin
                        m_exp = d ? q_b.pop_front() : q_a.pop_front();
                        check_output(d ? "row_data_b" : "row_data_a", m_data, m_exp.data);
                        check_output(d ? "row_idx_b" : "row_idx_a", OUT_W'(m_idx), OUT_W'(m_exp.idx));
                        check_output(d ? "row_last_b" : "row_last_a", OUT_W'(m_last), OUT_W'(m_exp.last));
                        exp_done[d] = m_exp.last;
                    end
                end
            end
        end
    end

    task automatic check_quiet(input string name);
        check_output({name, "_in_ready"},  OUT_W'(ifa.in_ready),    '0);
        check_output({name, "_out_valid"}, OUT_W'(ifa.out_valid),   '0);
        check_output({name, "_out_last"},  OUT_W'(ifa.out_last),    '0);
        check_output({name, "_done"},      OUT_W'(done_a),          '0);
        check_output({name, "_row_idx"},   OUT_W'(ifa.out_row_idx), '0);
        check_output({name, "_in_ready_b"}, OUT_W'(ifb.in_ready),   '0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        ifa.in_valid = 1'b0;
        ifb.in_valid = 1'b0;
        ifa.in_data  = '0;
        ifb.in_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_quiet("reset");
        @(posedge clk); #1;

        $display("[TB] frame with r*8+c pattern, no stalls");
        fill_matrix(1'b1);
        start_frame();
        @(negedge clk);
        check_output("run_in_ready", OUT_W'(ifa.in_ready), OUT_W'(1));
        @(posedge clk); #1;
        apply_stimulus(0, NTC * NTR, 0);
        wait_frame("pattern");

        $display("[TB] full backpressure: both banks fill, row 0 held");
        out_ready_pct = 0;
        fill_matrix(1'b0);
        start_frame();
        apply_stimulus(0, NTC * NTR, 0);
        ifa.in_valid = 1'b1;
        ifb.in_valid = 1'b1;
        ifa.in_data  = ~ifa.in_data;
        ifb.in_data  = ~ifb.in_data;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_output("stall_in_ready", OUT_W'(ifa.in_ready), '0);
            check_output("stall_out_valid", OUT_W'(ifa.out_valid), OUT_W'(1));
            check_output("stall_row_idx", OUT_W'(ifa.out_row_idx), '0);
            check_output("stall_row0_a", ifa.out_data, pack_row(0, 1'b0));
            check_output("stall_row0_b", ifb.out_data, pack_row(0, 1'b1));
            @(posedge clk); #1;
        end
        ifa.in_valid = 1'b0;
        ifb.in_valid = 1'b0;
        out_ready_pct = 100;
        wait_frame("backpressure");

        $display("[TB] release output while final beat pending");
        out_ready_pct = 0;
        fill_matrix(1'b0);
        start_frame();
        apply_stimulus(0, NTC * NTR - 1, 0);
        out_ready_pct = 100;
        apply_stimulus(NTC * NTR - 1, 1, 0);
        wait_frame("release");

        $display("[TB] reset mid-frame after 3 beats");
        out_ready_pct = 0;
        fill_matrix(1'b0);
        start_frame();
        apply_stimulus(0, 3, 0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check_quiet("midreset");
        q_a.delete();
        q_b.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready_pct = 100;
        fill_matrix(1'b0);
        start_frame();
        apply_stimulus(0, NTC * NTR, 10);
        wait_frame("after_reset");

        $display("[TB] random frames with input and output gaps");
        for (int f = 0; f < 3; f++) begin
            out_ready_pct = 50 + f * 10;
            fill_matrix(1'b0);
            start_frame();
            apply_stimulus(0, NTC * NTR, 40);
            wait_frame("random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
